// File: rtl/hazard_sched.sv
// hazard_sched -- pipeline sequencing controller beside the decode stage.
//
// Schedules load-use stalls, jump/branch flushes and arbitration of the single
// register-file port between write-back and decode operand reads. Keeps
// saturating stall and flush counters for bring-up.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid, id_rs1, id_rs2   decode instruction and its source registers
//   id_use_rs1, id_use_rs2     decode instruction actually reads rs1 / rs2
//   ex_mem_read, ex_rd         EX instruction is a load, and its destination
//   control_j                  decode resolved a taken jump/branch
//   wb_op_write                write-back requests the RF port
//   pc_write, pc_sel_j         PC update enable, select jump target
//   ifid_write, ifid_flush     IF/ID load enable, load a NOP
//   idex_bubble                zero the ID/EX control bits
//   rf_read_en                 decode owns the RF port this cycle
//   wb_hold                    write-back must hold its write one cycle
//   stall_cnt, flush_cnt       saturating performance counters
//
// In both the taken-jump cycle and the FLUSH cycles, IF/ID is loaded with a
// NOP, so ifid_write and ifid_flush are both high there.

module hazard_sched #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_RF_WAIT  = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             control_j,
  input  logic             wb_op_write,
  output logic             pc_write,
  output logic             pc_sel_j,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             rf_read_en,
  output logic             wb_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    RF_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [2:0] LU_INIT  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FL_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] WAIT_MAX = 3'(MAX_RF_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [2:0] wait_cnt, wait_nxt;
  logic       flush_ev;
  logic       lu;
  logic       rfc;

  // Hazard terms. x0 is hard-wired zero, so a load targeting it never stalls.
  // The RF conflict ignores register numbers: any read collides with write-back.
  always_comb begin
    lu  = id_valid & ex_mem_read & (ex_rd != 5'd0) &
          ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    rfc = id_valid & (id_use_rs1 | id_use_rs2) & wb_op_write;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wait_nxt    = wait_cnt;
    flush_ev    = 1'b0;
    pc_write    = 1'b0;
    pc_sel_j    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    rf_read_en  = 1'b0;
    wb_hold     = 1'b0;

    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = 3'd0;
      wait_nxt    = 3'd0;
    end else begin
      case (state)
        RUN: begin
          wait_nxt = 3'd0;
          if (control_j && id_valid) begin
            // Jump wins over any hazard: the sequential instructions behind it
            // are discarded anyway.
            pc_write   = 1'b1;
            pc_sel_j   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            flush_ev   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = FL_INIT;
            end else begin
              state_nxt = RUN;
            end
          end else if (lu) begin
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LU_STALL;
              cnt_nxt   = LU_INIT;
            end else begin
              state_nxt = RUN;
            end
          end else if (rfc) begin
            // Write-back keeps the port; decode waits.
            idex_bubble = 1'b1;
            wait_nxt    = 3'd1;
            state_nxt   = RF_WAIT;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            rf_read_en = id_valid;
          end
        end

        LU_STALL: begin
          idex_bubble = 1'b1;
          // The counter holds the remaining stall cycles including this one.
          if (cnt <= 3'd1) begin
            cnt_nxt   = 3'd0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end

        RF_WAIT: begin
          if (!wb_op_write) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            rf_read_en = 1'b1;
            wait_nxt   = 3'd0;
            state_nxt  = RUN;
          end else if (wait_cnt >= WAIT_MAX) begin
            // Starvation limit: decode takes the port, write-back holds.
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            rf_read_en = 1'b1;
            wb_hold    = 1'b1;
            wait_nxt   = 3'd0;
            state_nxt  = RUN;
          end else begin
            idex_bubble = 1'b1;
            wait_nxt    = wait_cnt + 3'd1;
          end
        end

        FLUSH: begin
          // control_j is ignored here: decode holds a flushed, invalid slot.
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt <= 3'd1) begin
            cnt_nxt   = 3'd0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end

        default: begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
          wait_nxt  = 3'd0;
        end
      endcase
    end
  end

  // State, sequencing counters and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= 3'd0;
      wait_cnt  <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_write && (stall_cnt != CNT_SAT)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_ev && (flush_cnt != CNT_SAT)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched. Two instances with different parameters
// (A: LOAD_LAT=1 FLUSH_CYCLES=2 CNT_W=16, B: LOAD_LAT=3 FLUSH_CYCLES=1 CNT_W=4).
// The driver applies directed vectors and pushes the hand-computed response;
// the monitor pops and compares on the falling edge.

module tb_hazard_sched;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] exrd;
    logic       cj;
    logic       wb;
  } in_t;

  typedef struct {
    bit         dut;
    logic [6:0] o;
    int         s;
    int         f;
    int         id;
  } exp_t;

  // Output pattern: {pc_write,pc_sel_j,ifid_write,ifid_flush,idex_bubble,rf_read_en,wb_hold}
  localparam logic [6:0] ADV_R = 7'b1010010;
  localparam logic [6:0] ADV_N = 7'b1010000;
  localparam logic [6:0] STL   = 7'b0000100;
  localparam logic [6:0] JMP   = 7'b1111000;
  localparam logic [6:0] FLS   = 7'b1011100;
  localparam logic [6:0] HLD   = 7'b1010011;
  localparam logic [6:0] RST   = 7'b0001100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t in_a, in_b;
  logic        a_pw, a_psj, a_iw, a_if, a_bub, a_rf, a_wh;
  logic        b_pw, b_psj, b_iw, b_if, b_bub, b_rf, b_wh;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  hazard_sched #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .MAX_RF_WAIT(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(in_a.rst), .id_valid(in_a.valid), .id_rs1(in_a.rs1), .id_rs2(in_a.rs2),
    .id_use_rs1(in_a.u1), .id_use_rs2(in_a.u2), .ex_mem_read(in_a.mr), .ex_rd(in_a.exrd),
    .control_j(in_a.cj), .wb_op_write(in_a.wb),
    .pc_write(a_pw), .pc_sel_j(a_psj), .ifid_write(a_iw), .ifid_flush(a_if),
    .idex_bubble(a_bub), .rf_read_en(a_rf), .wb_hold(a_wh), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_sched #(.LOAD_LAT(3), .FLUSH_CYCLES(1), .MAX_RF_WAIT(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(in_b.rst), .id_valid(in_b.valid), .id_rs1(in_b.rs1), .id_rs2(in_b.rs2),
    .id_use_rs1(in_b.u1), .id_use_rs2(in_b.u2), .ex_mem_read(in_b.mr), .ex_rd(in_b.exrd),
    .control_j(in_b.cj), .wb_op_write(in_b.wb),
    .pc_write(b_pw), .pc_sel_j(b_psj), .ifid_write(b_iw), .ifid_flush(b_if),
    .idex_bubble(b_bub), .rf_read_en(b_rf), .wb_hold(b_wh), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  function automatic in_t mk(input logic rst, input logic valid, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic u1, input logic u2,
                             input logic mr, input logic [4:0] exrd, input logic cj,
                             input logic wb);
    in_t v;
    v.rst = rst; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.exrd = exrd; v.cj = cj; v.wb = wb;
    return v;
  endfunction

  function automatic int min15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // Drive one cycle of stimulus on one instance and record the expected response.
  task automatic step(input bit dut, input in_t v, input logic [6:0] eo,
                      input int es, input int ef, input int id);
    exp_t e;
    @(posedge clk);
    #1;
    if (dut) begin
      in_b = v;
      in_a = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    end else begin
      in_a = v;
      in_b = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    end
    e.dut = dut; e.o = eo; e.s = es; e.f = ef; e.id = id;
    q.push_back(e);
  endtask

  // Monitor: pop one expectation per cycle and compare against the addressed instance.
  initial begin
    exp_t e;
    logic [6:0] ao;
    int as_, af;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut) begin
          ao = {b_pw, b_psj, b_iw, b_if, b_bub, b_rf, b_wh};
          as_ = int'(b_sc); af = int'(b_fc);
        end else begin
          ao = {a_pw, a_psj, a_iw, a_if, a_bub, a_rf, a_wh};
          as_ = int'(a_sc); af = int'(a_fc);
        end
        total++;
        if (ao === e.o) passed++;
        else $display("FAIL outputs dut=%0d vec=%0d got=%b want=%b", e.dut, e.id, ao, e.o);
        total++;
        if (as_ == e.s) passed++;
        else $display("FAIL stall_cnt dut=%0d vec=%0d got=%0d want=%0d", e.dut, e.id, as_, e.s);
        total++;
        if (af == e.f) passed++;
        else $display("FAIL flush_cnt dut=%0d vec=%0d got=%0d want=%0d", e.dut, e.id, af, e.f);
      end
    end
  end

  // Directed stimulus.
  initial begin
    in_t idle_v, hz, lu5, rd3, rd3wb, jmp3;
    idle_v = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    hz     = mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    lu5    = hz;
    rd3    = mk(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rd3wb  = mk(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    jmp3   = mk(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);

    in_a = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    in_b = in_a;
    repeat (2) @(posedge clk);

    // Instance A: LOAD_LAT=1, FLUSH_CYCLES=2, MAX_RF_WAIT=2
    step(1'b0, mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), RST, 0, 0, 1);
    step(1'b0, rd3, ADV_R, 0, 0, 2);
    step(1'b0, lu5, STL, 0, 0, 3);
    step(1'b0, mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0), ADV_R, 1, 0, 4);
    step(1'b0, mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0), ADV_R, 1, 0, 5);
    step(1'b0, mk(1'b0, 1'b1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0), ADV_R, 1, 0, 6);
    step(1'b0, mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0), JMP, 1, 0, 7);
    step(1'b0, mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0), FLS, 1, 1, 8);
    step(1'b0, rd3, ADV_R, 1, 1, 9);
    step(1'b0, rd3wb, STL, 1, 1, 10);
    step(1'b0, rd3wb, STL, 2, 1, 11);
    step(1'b0, rd3wb, HLD, 3, 1, 12);
    step(1'b0, rd3wb, STL, 3, 1, 13);
    step(1'b0, rd3, ADV_R, 4, 1, 14);
    step(1'b0, idle_v, ADV_N, 4, 1, 15);
    step(1'b0, mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), ADV_N, 4, 1, 16);
    step(1'b0, jmp3, JMP, 4, 1, 17);
    step(1'b0, idle_v, FLS, 4, 2, 18);
    step(1'b0, idle_v, ADV_N, 4, 2, 19);

    // Instance B: LOAD_LAT=3, FLUSH_CYCLES=1, CNT_W=4
    step(1'b1, mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), RST, 0, 0, 101);
    step(1'b1, lu5, STL, 0, 0, 102);
    step(1'b1, mk(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0), RST, 1, 0, 103);
    step(1'b1, rd3, ADV_R, 0, 0, 104);
    step(1'b1, lu5, STL, 0, 0, 105);
    step(1'b1, rd3, STL, 1, 0, 106);
    step(1'b1, rd3, STL, 2, 0, 107);
    step(1'b1, rd3, ADV_R, 3, 0, 108);
    step(1'b1, jmp3, JMP, 3, 0, 109);
    step(1'b1, rd3, ADV_R, 3, 1, 110);
    for (int i = 0; i < 21; i++) step(1'b1, lu5, STL, min15(3 + i), 1, 200 + i);
    step(1'b1, rd3, ADV_R, 15, 1, 230);
    for (int j = 0; j < 16; j++) step(1'b1, jmp3, JMP, 15, min15(1 + j), 300 + j);
    step(1'b1, rd3, ADV_R, 15, 15, 330);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline sequencing controller sitting beside the decode stage.
- Schedules stalls, bubbles and flushes for load-use hazards and taken jumps/branches.
- Arbitrates the single register-file port between write-back writes and decode-stage operand reads.
- Keeps saturating stall and flush counters for bring-up.

Parameters:
- LOAD_LAT, 1, number of bubble cycles inserted for a load-use hazard (1..7).
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a taken jump/branch (1..3).
- MAX_RF_WAIT, 2, consecutive cycles decode may lose the RF port before write-back is held (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1  in  5  decode source register 1.
- id_rs2  in  5  decode source register 2.
- id_use_rs1  in  1  decode instruction reads rs1.
- id_use_rs2  in  1  decode instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load (MemRead control bit).
- ex_rd  in  5  destination register of the EX instruction.
- control_j  in  1  decode resolved a taken jump/branch; pc_j is valid.
- wb_op_write  in  1  write-back requests the RF port this cycle.
- pc_write  out  1  PC may update.
- pc_sel_j  out  1  PC loads pc_j instead of pc+4.
- ifid_write  out  1  IF/ID register may load.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_bubble  out  1  ID/EX control bits are forced to 0.
- rf_read_en  out  1  decode owns the RF port and samples operands.
- wb_hold  out  1  write-back must hold its write for one cycle.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_cnt  out  CNT_W  saturating count of flush events.

Behaviour:
- States: RUN, LU_STALL, RF_WAIT, FLUSH. Reset (synchronous) -> RUN; all counters 0.
- Outputs are combinational from state and inputs. While reset=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, rf_read_en=0, wb_hold=0, pc_sel_j=0.
- Hazard terms:
  - lu = id_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - rfc = id_valid & (id_use_rs1|id_use_rs2) & wb_op_write.
- RUN, priority order when several conditions hold:
  - control_j & id_valid: pc_write=1, pc_sel_j=1, ifid_flush=1, flush_cnt+1. If FLUSH_CYCLES>1, go FLUSH with counter=FLUSH_CYCLES-1.
  - else lu: pc_write=0, ifid_write=0, idex_bubble=1. Go LU_STALL with counter=LOAD_LAT-1 if LOAD_LAT>1; otherwise stay RUN.
  - else rfc: write-back wins the port. pc_write=0, ifid_write=0, idex_bubble=1, rf_read_en=0, wait=1. Go RF_WAIT.
  - else: pc_write=1, ifid_write=1, rf_read_en=id_valid; all other outputs 0.
- LU_STALL: same outputs as the lu case. Decrement the counter; at 0 return to RUN. Re-evaluation happens in RUN.
- RF_WAIT:
  - if !wb_op_write: rf_read_en=1, outputs as normal RUN advance, go RUN, wait cleared.
  - else if wait==MAX_RF_WAIT: wb_hold=1, rf_read_en=1, normal advance, go RUN.
  - else: stall as in the rfc case, wait+1.
- FLUSH: pc_write=1, pc_sel_j=0, ifid_flush=1, idex_bubble=1. Decrement the counter; at 0 go RUN. A control_j here is ignored, since the flushed instruction is invalid.
- stall_cnt increments each cycle pc_write=0 outside reset. Both counters saturate at all-ones and do not wrap.
- x0 never causes a load-use stall. RF conflict uses id_use_* only and ignores register numbers.
- Reset asserted mid-stall or mid-flush: next cycle is RUN, counters 0, wait 0.
- Latency: hazard detection to stall output is 0 cycles (same cycle). State changes take effect next cycle.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LOAD_LAT=1 -> exactly 1 cycle pc_write=0/idex_bubble=1, then advance; stall_cnt=1.
- x0 and no-use: ex_rd=0 with id_rs1=0, then ex_rd=6 with id_rs2=6 but id_use_rs2=0 -> no stall either case.
- Jump plus hazard same cycle: control_j=1 and lu=1 -> pc_sel_j=1, ifid_flush=1, no stall. With FLUSH_CYCLES=2 -> 2 flush cycles total, flush_cnt=1.
- RF arbitration: wb_op_write high 4 cycles, id reads rs1, MAX_RF_WAIT=2 -> 2 stall cycles, then wb_hold=1 with rf_read_en=1 in the third cycle.
- Reset mid-LU_STALL with LOAD_LAT=3, reset pulsed in cycle 2 -> reset outputs during reset, RUN after, counters 0.
- Saturation with CNT_W=4: force 20 stall cycles -> stall_cnt holds at 15.
